cell_reduce_pipe: RTL and testbench
===================================

Name: cell_reduce_pipe

Overview:
- Parametrised, pipelined successor of the fuzz-style single-bit combinational cell network.
- Evaluates LANES independent 3-input cell functions over a wide in_data word, with a runtime-selectable function mode.
- Registers results through a 2-stage valid/ready pipeline into out_data.
- Sits between the stimulus driver and the result checker in the fuzz harness; adds backpressure and a result-hit counter.

Parameters:
W, 96, width of in_data and out_data
LANES, 1, number of evaluated lanes (1..W)
A_BASE, 64, in_data index of operand a for lane 0
B_BASE, 72, in_data index of operand b for lane 0
C_BASE, 43, in_data index of operand c for lane 0
OUT_BASE, 32, out_data index of the lane 0 result
CW, 16, hit_count width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block accepts the input word this cycle
in_data  input  W  stimulus word
mode  input  2  cell function, sampled with in_data on acceptance
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  W  result word
hit_count  output  CW  count of delivered words with at least one lane result = 1

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low: rst_n.
- Lane i operands:
  - a = in_data[(A_BASE+i)%W]
  - b = in_data[(B_BASE+i)%W]
  - c = in_data[(C_BASE+i)%W]
  - Indices wrap modulo W.
- Lane i result drives out_data[(OUT_BASE+i)%W]. All other out_data bits are 0.
  - If two lanes map to the same out bit, results are ORed.
- Modes:
  - 0 NAND_OR: a | ~(b & c)
  - 1 AND_OR: a | (b & c)
  - 2 XOR3: a ^ b ^ c
  - 3 PASS: a
- Stage 1 registers the operand bits of all lanes, plus mode and s1_valid.
- Stage 2 registers the evaluated out_data word and out_valid.
- Latency: a word accepted in cycle N is presented on out_data in cycle N+2 when the pipeline is not stalled.
- Throughput: 1 word/cycle.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - s2 advances when !out_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = rst_n & (s1 advances). This is a combinational path from out_ready to in_ready; there is no path from in_valid to out_valid.
- Stall: out_data, out_valid and stage-1 contents hold while out_valid & !out_ready. Under stall, out_data never changes while out_valid is high.
- Reset (rst_n low at a clock edge, including mid-operation):
  - s1_valid=0, out_valid=0, out_data=0, hit_count=0, stage-1 operands=0.
  - in_ready=0 while rst_n is low.
  - In-flight words are dropped.
- hit_count increments by 1 on each output transfer whose out_data != 0.
  - Saturates at 2^CW-1; it never wraps.
- mode is ignored when no transfer occurs.

Optional Feature:
- Macro: CELL_REDUCE_STATS_EN.
- Defined: hit_count counts as above.
- Undefined: the counter logic is omitted and hit_count is tied to 0. Datapath and handshake are identical.

Decomposition:
- Package cell_reduce_pkg:
  - cell_mode_e enum (NAND_OR, AND_OR, XOR3, PASS)
  - function lane_idx(base, i, w) returning (base+i)%w
  - CELL_MODE_W = 2
- Sub-module cell_lane_eval: purely combinational single-lane evaluator (a, b, c, mode -> r), instantiated LANES times in stage 2.

Test Plan:
- Defaults, mode 0, out_ready=1: in_data bit64=0, bit72=1, bit43=1, accepted at cycle 0 -> cycle 2 out_valid=1, out_data=0, hit_count stays 0. Then bit72=0 -> out_data[32]=1, all other bits 0, hit_count=1.
- Modes 1/2/3 with a=0, b=1, c=1 -> out_data[32] = 1, 0, 0 respectively.
- Backpressure: stream 4 words, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepted words, out_data is stable throughout, all 4 words arrive in order, none dropped or duplicated.
- LANES=4, OUT_BASE=94, W=96 -> lane results land on bits 94, 95, 0, 1. Operand indices wrap correctly (A_BASE=95 gives lane 1 operand a = bit 0).
- Reset mid-stream with 2 words in flight -> next cycle out_valid=0, out_data=0, hit_count=0, in_ready=0 while rst_n=0. No stale word appears after release.
- CW=2 with 5 nonzero results -> hit_count saturates at 3. With CELL_REDUCE_STATS_EN undefined -> hit_count stays 0.

Source files
------------

// File: rtl/cell_reduce_pkg.sv
// Shared types and helpers for the cell_reduce_pipe slice: cell function modes
// and the wrapped lane-to-bit index mapping.
package cell_reduce_pkg;

  localparam int CELL_MODE_W = 2;

  typedef enum logic [CELL_MODE_W-1:0] {
    NAND_OR = 2'd0,
    AND_OR  = 2'd1,
    XOR3    = 2'd2,
    PASS    = 2'd3
  } cell_mode_e;

  function automatic int lane_idx(input int base, input int i, input int w);
    return (base + i) % w;
  endfunction

endpackage

// File: rtl/cell_reduce_pipe_lane.sv
// Single-lane 3-input cell evaluator; purely combinational.
module cell_lane_eval
  import cell_reduce_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  cell_mode_e mode,
  output logic       r
);

  always_comb begin
    r = a;
    case (mode)
      NAND_OR: r = a | ~(b & c);
      AND_OR:  r = a | (b & c);
      XOR3:    r = a ^ b ^ c;
      PASS:    r = a;
      default: r = a;
    endcase
  end

endmodule

// File: rtl/cell_reduce_pipe.sv
// Two-stage valid/ready pipeline evaluating LANES cell functions over in_data.
// Optional macro CELL_REDUCE_STATS_EN enables the saturating hit_count.
module cell_reduce_pipe
  import cell_reduce_pkg::*;
#(
  parameter int W        = 96,
  parameter int LANES    = 1,
  parameter int A_BASE   = 64,
  parameter int B_BASE   = 72,
  parameter int C_BASE   = 43,
  parameter int OUT_BASE = 32,
  parameter int CW       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic [CELL_MODE_W-1:0] mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [CW-1:0]          hit_count
);

  // Handshake: a word moves on any edge where valid & ready are both high;
  // a stage refills when it is empty or its content leaves this cycle, so
  // in_ready depends combinationally on out_ready but never on in_valid.
  logic             s2_adv;
  logic             s1_adv;
  logic             s1_valid;
  logic [LANES-1:0] op_a, op_b, op_c;
  logic [LANES-1:0] s1_a, s1_b, s1_c;
  cell_mode_e       s1_mode;
  logic [LANES-1:0] lane_r;
  logic [W-1:0]     lane_word [LANES];
  logic [W-1:0]     eval_word;
  logic             unused_in;

  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = rst_n && s1_adv;
  assign unused_in = ^in_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int AI = lane_idx(A_BASE, i, W);
    localparam int BI = lane_idx(B_BASE, i, W);
    localparam int CI = lane_idx(C_BASE, i, W);
    localparam int OI = lane_idx(OUT_BASE, i, W);

    assign op_a[i] = in_data[AI];
    assign op_b[i] = in_data[BI];
    assign op_c[i] = in_data[CI];

    cell_lane_eval u_eval (
      .a    (s1_a[i]),
      .b    (s1_b[i]),
      .c    (s1_c[i]),
      .mode (s1_mode),
      .r    (lane_r[i])
    );

    assign lane_word[i] = {{(W-1){1'b0}}, lane_r[i]} << OI;
  end

  // Lanes sharing an output bit are merged by OR.
  always_comb begin
    eval_word = '0;
    for (int i = 0; i < LANES; i++) begin
      eval_word = eval_word | lane_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_mode  <= NAND_OR;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= op_a;
        s1_b    <= op_b;
        s1_c    <= op_c;
        s1_mode <= cell_mode_e'(mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= eval_word;
      end
    end
  end

`ifdef CELL_REDUCE_STATS_EN
  logic [CW-1:0] hit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (out_valid && out_ready && (|out_data) && (hit_q != {CW{1'b1}})) begin
      hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_count = hit_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_cell_reduce_pipe.sv
// Bench for cell_reduce_pipe: default instance plus a 4-lane wrapping, CW=2 instance
// sharing one stimulus stream, checked against a queue-based reference model.
module tb_cell_reduce_pipe;

`ifdef CELL_REDUCE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [95:0] in_data;
  logic [1:0]  mode;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [95:0] out_data0, out_data1;
  logic [15:0] hit_count0;
  logic [1:0]  hit_count1;

  int          vectors;
  int          miscompares;
  logic [95:0] exp_q0[$];
  logic [95:0] exp_q1[$];
  int          exp_hit0, exp_hit1;
  bit          bp_rand;
  logic        rst_prev, stall_prev;
  logic [95:0] held0, held1;

  cell_reduce_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .hit_count(hit_count0)
  );

  cell_reduce_pipe #(
    .W(96), .LANES(4), .A_BASE(95), .B_BASE(72), .C_BASE(43), .OUT_BASE(94), .CW(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .hit_count(hit_count1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: each lane picks bits by wrapped index, applies the mode rule
  function automatic logic [95:0] model(input logic [95:0] d, input logic [1:0] m,
                                        input int lanes, input int ab, input int bb,
                                        input int cb, input int ob);
    logic [95:0] r;
    int a, b, c, y;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      a = int'(d[(ab + i) % 96]);
      b = int'(d[(bb + i) % 96]);
      c = int'(d[(cb + i) % 96]);
      case (m)
        2'd0:    y = (a == 1 || (b + c) < 2) ? 1 : 0;
        2'd1:    y = (a == 1 || (b + c) == 2) ? 1 : 0;
        2'd2:    y = (a + b + c) % 2;
        default: y = a;
      endcase
      if (y == 1) r[(ob + i) % 96] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [95:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // scoreboard / monitor, called once per cycle at the falling edge
  task automatic monitor(output logic fired);
    logic [95:0] e0, e1;
    logic [15:0] ehc0;
    logic [1:0]  ehc1;
    fired = in_valid && in_ready0;
    vectors++;
    if (in_ready1 !== in_ready0 || out_valid1 !== out_valid0) begin
      miscompares++;
      $display("FAIL handshake_match: dut1 rdy/vld=%b%b dut0 rdy/vld=%b%b",
               in_ready1, out_valid1, in_ready0, out_valid0);
    end
    if (!rst_n) begin
      vectors++;
      if (in_ready0 !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_in_ready: got %b want 0", in_ready0);
      end
      if (rst_prev) begin
        vectors++;
        if ({out_valid0, out_valid1, out_data0, out_data1, hit_count0, hit_count1} !== '0) begin
          miscompares++;
          $display("FAIL rst_state: vld=%b%b d0=%h d1=%h hc=%0d/%0d want all 0",
                   out_valid0, out_valid1, out_data0, out_data1, hit_count0, hit_count1);
        end
      end
      exp_q0.delete();
      exp_q1.delete();
      exp_hit0   = 0;
      exp_hit1   = 0;
      stall_prev = 1'b0;
      fired      = 1'b0;
    end else begin
      ehc0 = STATS ? 16'(exp_hit0) : 16'd0;
      ehc1 = STATS ? 2'(exp_hit1) : 2'd0;
      vectors++;
      if (hit_count0 !== ehc0 || hit_count1 !== ehc1) begin
        miscompares++;
        $display("FAIL hit_count: got %0d/%0d want %0d/%0d", hit_count0, hit_count1, ehc0, ehc1);
      end
      if (stall_prev) begin
        vectors++;
        if (out_valid0 !== 1'b1 || out_data0 !== held0 || out_data1 !== held1) begin
          miscompares++;
          $display("FAIL stall_hold: vld=%b d0=%h d1=%h want 1 %h %h",
                   out_valid0, out_data0, out_data1, held0, held1);
        end
      end
      if (out_valid0 === 1'b1 && out_ready) begin
        vectors++;
        if (exp_q0.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: got %h with no word expected", out_data0);
        end else begin
          e0 = exp_q0.pop_front();
          e1 = exp_q1.pop_front();
          if (out_data0 !== e0 || out_data1 !== e1) begin
            miscompares++;
            $display("FAIL out_data: got %h / %h want %h / %h", out_data0, out_data1, e0, e1);
          end
          if (e0 != '0 && exp_hit0 < 65535) exp_hit0++;
          if (e1 != '0 && exp_hit1 < 3) exp_hit1++;
        end
      end
      if (fired) begin
        exp_q0.push_back(model(in_data, mode, 1, 64, 72, 43, 32));
        exp_q1.push_back(model(in_data, mode, 4, 95, 72, 43, 94));
      end
      stall_prev = out_valid0 && !out_ready;
      held0 = out_data0;
      held1 = out_data1;
    end
    rst_prev = !rst_n;
  endtask

  // driver tasks
  task automatic tick(output logic fired);
    @(negedge clk);
    monitor(fired);
    @(posedge clk);
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  task automatic send_word(input logic [95:0] d, input logic [1:0] m);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 200) begin
      tick(acc);
      guard++;
    end
    in_valid = 1'b0;
    in_data  = rand_word();
    mode     = 2'($urandom_range(0, 3));
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %h not accepted in %0d cycles", d, guard);
    end
  endtask

  task automatic drain();
    int guard;
    bp_rand   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    guard     = 0;
    while ((exp_q0.size() != 0 || out_valid0 === 1'b1) && guard < 300) begin
      idle(1);
      guard++;
    end
    vectors++;
    if (exp_q0.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words outstanding want 0", exp_q0.size());
    end
    idle(1);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'd0;
    out_ready = 1'b1;
    bp_rand   = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_mode0_latency();
    logic [95:0] d, one32;
    one32 = 96'd1 << 32;
    d = rand_word();
    d[64] = 1'b0; d[72] = 1'b1; d[43] = 1'b1;
    send_word(d, 2'd0);
    vectors++;
    if (out_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_c1: out_valid=%b want 0", out_valid0);
    end
    idle(1);
    vectors++;
    if (out_valid0 !== 1'b1 || out_data0 !== '0 || hit_count0 !== 16'd0) begin
      miscompares++;
      $display("FAIL latency_c2: vld=%b data=%h hc=%0d want 1 0 0", out_valid0, out_data0, hit_count0);
    end
    idle(1);
    d[72] = 1'b0;
    send_word(d, 2'd0);
    idle(1);
    vectors++;
    if (out_valid0 !== 1'b1 || out_data0 !== one32) begin
      miscompares++;
      $display("FAIL mode0_hit: vld=%b data=%h want 1 %h", out_valid0, out_data0, one32);
    end
    idle(2);
    vectors++;
    if (hit_count0 !== (STATS ? 16'd1 : 16'd0)) begin
      miscompares++;
      $display("FAIL mode0_count: got %0d want %0d", hit_count0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_modes();
    logic [95:0] d, want;
    logic [2:0]  bit_by_mode;
    bit_by_mode = 3'b001;
    for (int m = 1; m <= 3; m++) begin
      d = rand_word();
      d[64] = 1'b0; d[72] = 1'b1; d[43] = 1'b1;
      want = bit_by_mode[m-1] ? (96'd1 << 32) : 96'd0;
      send_word(d, 2'(m));
      idle(1);
      vectors++;
      if (out_valid0 !== 1'b1 || out_data0 !== want) begin
        miscompares++;
        $display("FAIL mode%0d: vld=%b data=%h want 1 %h", m, out_valid0, out_data0, want);
      end
      idle(1);
    end
  endtask

  task automatic test_lane_wrap();
    logic [95:0] d, want;
    d = 96'd1;
    want = 96'd1 << 95;
    send_word(d, 2'd3);
    idle(1);
    vectors++;
    if (out_valid1 !== 1'b1 || out_data1 !== want) begin
      miscompares++;
      $display("FAIL lane_wrap: data=%h want %h", out_data1, want);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    bp_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_word(rand_word(), 2'($urandom_range(0, 3)));
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [95:0] words[4];
    logic [1:0]  modes[4];
    logic        f;
    int          k;
    for (int i = 0; i < 4; i++) begin
      words[i] = rand_word();
      modes[i] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1;
      in_data  = words[k];
      mode     = modes[k];
      tick(f);
      if (f) k++;
    end
    vectors++;
    if (k != 2 || in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: accepted %0d in_ready=%b want 2 0", k, in_ready0);
    end
    out_ready = 1'b1;
    while (k < 4) begin
      send_word(words[k], modes[k]);
      k++;
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send_word(rand_word(), 2'd3);
    send_word(~96'd0, 2'd3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(6);
    vectors++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stale: vld=%b%b want 00", out_valid0, out_valid1);
    end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) send_word(~96'd0, 2'd3);
    drain();
    vectors++;
    if (hit_count0 !== (STATS ? 16'd5 : 16'd0) || hit_count1 !== (STATS ? 2'd3 : 2'd0)) begin
      miscompares++;
      $display("FAIL saturation: got %0d/%0d want %0d/%0d",
               hit_count0, hit_count1, STATS ? 5 : 0, STATS ? 3 : 0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_hit0    = 0;
    exp_hit1    = 0;
    rst_prev    = 1'b0;
    stall_prev  = 1'b0;
    held0       = '0;
    held1       = '0;
    test_reset();
    test_mode0_latency();
    test_modes();
    test_lane_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
